// File: rtl/rv32i_bus_responder.sv
// Data-side bus responder for a small RV32I core: word RAM, GPIO/CYCLE/ERR_STATUS MMIO, sticky errors.
// Optional free-running CYCLE counter is built only when RV32I_BUS_CYCLE_COUNTER_EN is defined.
module rv32i_bus_responder #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wrdata,
    input  logic        bus_wren,
    input  logic        bus_rden,
    output logic [31:0] bus_rddata,
    output logic [31:0] gpio_out,
    output logic        bus_err
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   ram_off;
    logic [31:0]   mmio_off;
    logic [AW-1:0] ram_idx;
    logic [1:0]    reg_sel;
    logic          unaligned;
    logic          ram_hit;
    logic          mmio_hit;
    logic          wr_ok;
    logic          rd_ok;
    logic [31:0]   rd_next;
    logic [31:0]   cycle_val;
    logic [2:0]    err_q;
    logic [2:0]    err_set;
    logic [2:0]    err_clr;

    always_comb begin
        ram_off   = bus_addr - RAM_BASE;
        mmio_off  = bus_addr - MMIO_BASE;
        unaligned = (bus_addr[1:0] != 2'b00);
        ram_hit   = (bus_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
        mmio_hit  = (bus_addr >= MMIO_BASE) && (mmio_off < 32'd16);
        ram_idx   = ram_off[AW+1:2];
        reg_sel   = mmio_off[3:2];
        wr_ok     = bus_wren && !unaligned && (ram_hit || mmio_hit);
        // A simultaneous write wins; the read half is dropped entirely.
        rd_ok     = bus_rden && !bus_wren;
    end

    always_comb begin
        err_set[0] = (bus_wren || bus_rden) && unaligned;
        err_set[1] = (bus_wren || bus_rden) && !unaligned && !(ram_hit || mmio_hit);
        err_set[2] = bus_wren && bus_rden;
        err_clr    = (wr_ok && mmio_hit && reg_sel == 2'd2) ? bus_wrdata[2:0] : 3'b000;
    end

    always_comb begin
        rd_next = 32'h0;
        if (unaligned) begin
            rd_next = 32'h0;
        end else if (ram_hit) begin
            rd_next = ram[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                2'd0:    rd_next = gpio_out;
                2'd1:    rd_next = cycle_val;
                2'd2:    rd_next = {29'h0, err_q};
                default: rd_next = 32'h0;
            endcase
        end else begin
            rd_next = 32'hDEAD_BEEF;
        end
    end

    // RAM has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_ok && ram_hit) begin
            ram[ram_idx] <= bus_wrdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_rddata <= 32'h0;
            gpio_out   <= 32'h0;
            err_q      <= 3'b000;
        end else begin
            if (rd_ok) begin
                bus_rddata <= rd_next;
            end
            if (wr_ok && mmio_hit && reg_sel == 2'd0) begin
                gpio_out <= bus_wrdata;
            end
            err_q <= (err_q & ~err_clr) | err_set;
        end
    end

`ifdef RV32I_BUS_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= 32'h0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = 32'h0;
`endif

    assign bus_err = |err_q;

endmodule

// File: tb/tb_rv32i_bus_responder.sv
// Scoreboard bench for rv32i_bus_responder: expected read data is queued as reads are issued.
// Covers the RV32I_BUS_CYCLE_COUNTER_EN build when that macro is defined.
module tb_rv32i_bus_responder;

    localparam logic [31:0] RAM  = 32'h1000_0000;
    localparam logic [31:0] MMIO = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bus_addr = 32'h0;
    logic [31:0] bus_wrdata = 32'h0;
    logic        bus_wren = 1'b0;
    logic        bus_rden = 1'b0;
    logic [31:0] bus_rddata;
    logic [31:0] gpio_out;
    logic        bus_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    rv32i_bus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .bus_addr   (bus_addr),
        .bus_wrdata (bus_wrdata),
        .bus_wren   (bus_wren),
        .bus_rden   (bus_rden),
        .bus_rddata (bus_rddata),
        .gpio_out   (gpio_out),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one bus cycle from a falling edge; returns on the next falling edge.
    task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        bus_wren   = we;
        bus_rden   = re;
        bus_addr   = a;
        bus_wrdata = d;
        @(negedge clk);
        bus_wren = 1'b0;
        bus_rden = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        step(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic clr_err();
        step(1'b1, 1'b0, MMIO + 32'h8, 32'h7);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_rddata !== 32'h0) begin n_bad++; $display("FAIL reset_rddata: got %h expected %h", bus_rddata, 32'h0); end
        n_cmp++; if (gpio_out !== 32'h0) begin n_bad++; $display("FAIL reset_gpio: got %h expected %h", gpio_out, 32'h0); end
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", bus_err); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        step(1'b1, 1'b0, RAM + 32'h10, 32'hCAFE_F00D);
        rd(RAM + 32'h10, 32'hCAFE_F00D);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL wr_rd_next: got %h expected %h", bus_rddata, exp_v); end
        step(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++; if (bus_rddata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rddata_hold: got %h expected %h", bus_rddata, 32'hCAFE_F00D); end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, RAM + 32'h100 + 32'(4 * i), 32'h1111_0000 ^ 32'(i * 32'h0101_0101));
        step(1'b1, 1'b0, RAM + 32'hFFC, 32'h0BAD_CAFE);
        for (int i = 0; i < 4; i++) begin
            rd(RAM + 32'h100 + 32'(4 * i), 32'h1111_0000 ^ 32'(i * 32'h0101_0101));
            exp_v = exp_q.pop_front();
            n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL ram_pattern%0d: got %h expected %h", i, bus_rddata, exp_v); end
        end
        rd(RAM + 32'hFFC, 32'h0BAD_CAFE);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL ram_last_word: got %h expected %h", bus_rddata, exp_v); end
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL ram_no_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_unaligned();
        clr_err();
        rd(RAM + 32'h2, 32'h0);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL unaligned_rddata: got %h expected %h", bus_rddata, exp_v); end
        n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL unaligned_err: got %b expected 1", bus_err); end
        rd(MMIO + 32'h8, 32'h1);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL unaligned_status: got %h expected %h", bus_rddata, exp_v); end
        step(1'b1, 1'b0, MMIO + 32'h8, 32'h1);
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL w1c_clear: got %b expected 0", bus_err); end
        step(1'b1, 1'b0, RAM + 32'h12, 32'hFFFF_FFFF);
        rd(RAM + 32'h10, 32'hCAFE_F00D);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL unaligned_wr_blocked: got %h expected %h", bus_rddata, exp_v); end
    endtask

    task automatic test_unmapped();
        clr_err();
        rd(32'h0000_0100, 32'hDEAD_BEEF);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL unmapped_rddata: got %h expected %h", bus_rddata, exp_v); end
        rd(MMIO + 32'h8, 32'h2);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL unmapped_status: got %h expected %h", bus_rddata, exp_v); end
        clr_err();
        rd(RAM + 32'h1000, 32'hDEAD_BEEF);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL ram_end_unmapped: got %h expected %h", bus_rddata, exp_v); end
        rd(MMIO + 32'h10, 32'hDEAD_BEEF);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL mmio_end_unmapped: got %h expected %h", bus_rddata, exp_v); end
        step(1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678);
        rd(RAM + 32'h10, 32'hCAFE_F00D);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL unmapped_ram_kept: got %h expected %h", bus_rddata, exp_v); end
        rd(MMIO + 32'hC, 32'h0);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL reserved_reg: got %h expected %h", bus_rddata, exp_v); end
    endtask

    task automatic test_collision();
        clr_err();
        rd(RAM + 32'h10, 32'hCAFE_F00D);
        void'(exp_q.pop_front());
        step(1'b1, 1'b1, MMIO, 32'h5A);
        n_cmp++; if (gpio_out !== 32'h5A) begin n_bad++; $display("FAIL collision_gpio: got %h expected %h", gpio_out, 32'h5A); end
        n_cmp++; if (bus_rddata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL collision_rddata: got %h expected %h", bus_rddata, 32'hCAFE_F00D); end
        rd(MMIO + 32'h8, 32'h4);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL collision_status: got %h expected %h", bus_rddata, exp_v); end
        step(1'b1, 1'b1, MMIO + 32'h8, 32'h4);
        n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL set_wins: got %b expected 1", bus_err); end
        step(1'b1, 1'b0, MMIO + 32'h8, 32'h4);
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL w1c_bit2: got %b expected 0", bus_err); end
        rd(MMIO, 32'h5A);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL gpio_readback: got %h expected %h", bus_rddata, exp_v); end
    endtask

    task automatic test_cycle();
`ifdef RV32I_BUS_CYCLE_COUNTER_EN
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        @(negedge clk);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        rd(MMIO + 32'h4, 32'h0);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL cycle_wrap: got %h expected %h", bus_rddata, exp_v); end
        rd(MMIO + 32'h4, 32'h1);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL cycle_incr: got %h expected %h", bus_rddata, exp_v); end
`else
        rd(MMIO + 32'h4, 32'h0);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL cycle_absent: got %h expected %h", bus_rddata, exp_v); end
`endif
        step(1'b1, 1'b0, MMIO + 32'h4, 32'h1234);
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL cycle_wr_no_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_reset_mid_read();
        step(1'b1, 1'b0, RAM + 32'h20, 32'h1234_5678);
        step(1'b1, 1'b0, MMIO, 32'hA5);
        step(1'b0, 1'b1, RAM + 32'h20, 32'h0);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus_rddata !== 32'h0) begin n_bad++; $display("FAIL rst_mid_rddata: got %h expected %h", bus_rddata, 32'h0); end
        n_cmp++; if (gpio_out !== 32'h0) begin n_bad++; $display("FAIL rst_mid_gpio: got %h expected %h", gpio_out, 32'h0); end
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++; if (bus_rddata !== 32'h0) begin n_bad++; $display("FAIL rst_rddata_stays: got %h expected %h", bus_rddata, 32'h0); end
        rd(RAM + 32'h20, 32'h1234_5678);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus_rddata !== exp_v) begin n_bad++; $display("FAIL rst_ram_kept: got %h expected %h", bus_rddata, exp_v); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unaligned();
        test_unmapped();
        test_collision();
        test_cycle();
        test_reset_mid_read();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_bus_responder.md
RV32I_BUS_RESPONDER -- requirements
Module: rv32i_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, meaning the number of 32-bit data RAM words (power of two).
REQ-002 SHALL have parameter RAM_BASE, default 32'h1000_0000, meaning the RAM region base address.
REQ-003 SHALL have parameter MMIO_BASE, default 32'h2000_0000, meaning the MMIO region base address (16-byte window).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-006 SHALL have port bus_addr, input, 32 bits: byte address from the core.
REQ-007 SHALL have port bus_wrdata, input, 32 bits: write data from the core.
REQ-008 SHALL have port bus_wren, input, 1 bit: write strobe, sampled every cycle.
REQ-009 SHALL have port bus_rden, input, 1 bit: read strobe, sampled every cycle.
REQ-010 SHALL have port bus_rddata, output, 32 bits: registered read data returned to the core.
REQ-011 SHALL have port gpio_out, output, 32 bits: GPIO output register value.
REQ-012 SHALL have port bus_err, output, 1 bit: OR of all sticky error flags.

Function
REQ-013 SHALL decode as follows: RAM hit is bus_addr in [RAM_BASE, RAM_BASE+4*RAM_WORDS); MMIO hit is bus_addr in [MMIO_BASE, MMIO_BASE+16); any other address is unmapped.
REQ-014 SHALL map MMIO offsets as follows: 0x0 GPIO (R/W), 0x4 CYCLE (read-only), 0x8 ERR_STATUS (write-1-to-clear), 0xC reads 0, writes ignored.
REQ-015 SHALL commit a write on the edge where bus_wren=1, provided the address is aligned and mapped.
REQ-016 SHALL update bus_rddata exactly one cycle after bus_rden=1 and hold it until the next accepted read.
REQ-017 SHALL return the newly written word when a read of address A follows, in the next cycle, a write to A.
REQ-018 SHALL, for an unaligned access (bus_addr[1:0]!=0), not modify any state, load bus_rddata=0 on a read, and set ERR_STATUS bit0.
REQ-019 SHALL, for an unmapped access, not modify any state, load bus_rddata=32'hDEAD_BEEF on a read, and set ERR_STATUS bit1.
REQ-020 SHALL, when bus_wren=1 and bus_rden=1 in the same cycle, perform the write only, leave bus_rddata unchanged, and set ERR_STATUS bit2.
REQ-021 SHALL keep ERR_STATUS bits sticky until a write of 1 to that bit; when a clear and a new error occur in the same cycle, set wins.
REQ-022 SHALL drive bus_err = |ERR_STATUS[2:0] combinationally from the registered flags.
REQ-023 SHALL increment CYCLE by 1 every cycle after reset and wrap from 32'hFFFF_FFFF to 0.
REQ-024 SHALL give a CYCLE read the counter value sampled on the cycle bus_rden was asserted.
REQ-025 SHALL ignore writes to CYCLE without raising an error.

Reset
REQ-026 SHALL, while rst=0, force bus_rddata=0, gpio_out=0, CYCLE=0, ERR_STATUS=0, bus_err=0.
REQ-027 SHALL leave RAM contents untouched by reset; RAM is undefined at power-up.
REQ-028 SHALL abort any read in flight when rst asserts mid-operation; bus_rddata stays 0 until the first read after rst deasserts.

Configuration
REQ-029 SHALL, with macro RV32I_BUS_CYCLE_COUNTER_EN defined, implement CYCLE per REQ-023/024.
REQ-030 SHALL, without RV32I_BUS_CYCLE_COUNTER_EN, instantiate no counter flops and return 0 on a CYCLE read, with no error.

Verification
REQ-031 SHALL check write/read-back: write 32'hCAFE_F00D to RAM_BASE+0x10, read it in the next cycle -> bus_rddata=32'hCAFE_F00D one cycle after bus_rden.
REQ-032 SHALL check the unaligned read: read RAM_BASE+0x2 -> bus_rddata=0, ERR_STATUS=3'b001, bus_err=1; then write 32'h1 to MMIO_BASE+0x8 -> bus_err=0 on the next cycle.
REQ-033 SHALL check the unmapped read: read 32'h0000_0100 -> bus_rddata=32'hDEAD_BEEF, ERR_STATUS bit1=1, RAM unchanged.
REQ-034 SHALL check collision: bus_wren=bus_rden=1 to MMIO_BASE with data 32'h5A -> gpio_out=32'h5A, bus_rddata unchanged, ERR_STATUS bit2=1.
REQ-035 SHALL check the counter: force CYCLE to 32'hFFFF_FFFE, run 2 cycles -> 0; with the macro undefined a CYCLE read returns 0.
REQ-036 SHALL check reset mid-read: assert rst in the cycle after a RAM read strobe -> bus_rddata=0 and gpio_out=0 immediately, with RAM data retained.
